decode_writeback: RTL and testbench

//  SEQ decode + write-back stage, directly downstream of fetch. Holds the 15-entry
//  Y86-64 program register file. Derives srcA/srcB/dstE/dstM from icode/rA/rB/cnd
//  and reads valA/valB combinationally for execute/memory. Commits valE/valM on the

---
 rtl/y86_defs.sv | 81 ++++++++
 rtl/decode_writeback_if.sv | 32 +++
 rtl/y86_regfile.sv | 49 ++++
 rtl/decode_writeback.sv | 48 ++++
 tb/tb_decode_writeback.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/y86_defs.sv
// Shared Y86-64 definitions: instruction codes, register ids and the
// decode-stage register-id selection helper used by the pipeline stages.
package y86_defs;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_CMOVXX = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam logic [3:0] REG_RSP  = 4'h4;
    localparam logic [3:0] REG_NONE = 4'hF;
    localparam int         NUM_REGS = 15;

    typedef struct packed {
        logic [3:0] src_a;
        logic [3:0] src_b;
        logic [3:0] dst_e;
        logic [3:0] dst_m;
    } ids_t;

    function automatic ids_t decode_ids(
        input logic [3:0] icode,
        input logic [3:0] ra,
        input logic [3:0] rb,
        input logic       cnd
    );
        ids_t ids;
        ids = '{REG_NONE, REG_NONE, REG_NONE, REG_NONE};
        case (icode)
            ICODE_CMOVXX: begin
                ids.src_a = ra;
                ids.dst_e = cnd ? rb : REG_NONE;
            end
            ICODE_IRMOVQ: ids.dst_e = rb;
            ICODE_RMMOVQ: begin
                ids.src_a = ra;
                ids.src_b = rb;
            end
            ICODE_MRMOVQ: begin
                ids.src_b = rb;
                ids.dst_m = ra;
            end
            ICODE_OPQ: begin
                ids.src_a = ra;
                ids.src_b = rb;
                ids.dst_e = rb;
            end
            ICODE_CALL: begin
                ids.src_b = REG_RSP;
                ids.dst_e = REG_RSP;
            end
            ICODE_RET: begin
                ids.src_a = REG_RSP;
                ids.src_b = REG_RSP;
                ids.dst_e = REG_RSP;
            end
            ICODE_PUSHQ: begin
                ids.src_a = ra;
                ids.src_b = REG_RSP;
                ids.dst_e = REG_RSP;
            end
            ICODE_POPQ: begin
                ids.src_a = REG_RSP;
                ids.src_b = REG_RSP;
                ids.dst_e = REG_RSP;
                ids.dst_m = ra;
            end
            default: ;
        endcase
        return ids;
    endfunction

endpackage

// File: rtl/decode_writeback_if.sv
// Fetch/execute <-> decode-writeback bundle.
// master: upstream driver (instruction fields, commit data, debug select).
// slave:  the decode/write-back stage (register ids, read data, debug data).
interface decode_writeback_if #(
    parameter int DATA_W = 64
);
    logic [3:0]        icode;
    logic [3:0]        rA;
    logic [3:0]        rB;
    logic              cnd;
    logic              wb_en;
    logic [DATA_W-1:0] valE;
    logic [DATA_W-1:0] valM;
    logic [3:0]        srcA;
    logic [3:0]        srcB;
    logic [3:0]        dstE;
    logic [3:0]        dstM;
    logic [DATA_W-1:0] valA;
    logic [DATA_W-1:0] valB;
    logic [3:0]        dbg_sel;
    logic [DATA_W-1:0] dbg_val;

    modport master (
        output icode, rA, rB, cnd, wb_en, valE, valM, dbg_sel,
        input  srcA, srcB, dstE, dstM, valA, valB, dbg_val
    );

    modport slave (
        input  icode, rA, rB, cnd, wb_en, valE, valM, dbg_sel,
        output srcA, srcB, dstE, dstM, valA, valB, dbg_val
    );
endinterface

// File: rtl/y86_regfile.sv
// 15-entry Y86-64 register file: two combinational read ports plus a debug
// port, E and M write ports (M wins on collision), synchronous reset.
// Ports: clk, rst, r{a,b,dbg}_sel_i -> *_val_o, we_i, e/m dst+val inputs.
module y86_regfile
    import y86_defs::*;
#(
    parameter int                 DATA_W    = 64,
    parameter logic [DATA_W-1:0]  RSP_RESET = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        ra_sel_i,
    input  logic [3:0]        rb_sel_i,
    input  logic [3:0]        dbg_sel_i,
    output logic [DATA_W-1:0] ra_val_o,
    output logic [DATA_W-1:0] rb_val_o,
    output logic [DATA_W-1:0] dbg_val_o,
    input  logic              we_i,
    input  logic [3:0]        e_dst_i,
    input  logic [DATA_W-1:0] e_val_i,
    input  logic [3:0]        m_dst_i,
    input  logic [DATA_W-1:0] m_val_i
);
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // Id F has no storage; reading it yields zero.
    assign ra_val_o  = (ra_sel_i  == REG_NONE) ? '0 : regs_q[ra_sel_i];
    assign rb_val_o  = (rb_sel_i  == REG_NONE) ? '0 : regs_q[rb_sel_i];
    assign dbg_val_o = (dbg_sel_i == REG_NONE) ? '0 : regs_q[dbg_sel_i];

    // M is applied after E so popq %rsp keeps valM.
    always_comb begin
        regs_d = regs_q;
        if (we_i) begin
            if (e_dst_i != REG_NONE) regs_d[e_dst_i] = e_val_i;
            if (m_dst_i != REG_NONE) regs_d[m_dst_i] = m_val_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            regs_q[REG_RSP] <= RSP_RESET;
        end else begin
            regs_q <= regs_d;
        end
    end
endmodule

// File: rtl/decode_writeback.sv
// SEQ decode + write-back stage: register-id selection, read-data gating
// and the program register file. Ports: clk, rst, bus (slave modport).
module decode_writeback
    import y86_defs::*;
#(
    parameter int                 DATA_W    = 64,
    parameter logic [DATA_W-1:0]  RSP_RESET = '0
) (
    input  logic                clk,
    input  logic                rst,
    decode_writeback_if.slave   bus
);
    ids_t              ids;
    logic [DATA_W-1:0] ra_val;
    logic [DATA_W-1:0] rb_val;
    logic [DATA_W-1:0] dbg_val;

    assign ids = decode_ids(bus.icode, bus.rA, bus.rB, bus.cnd);

    assign bus.srcA = ids.src_a;
    assign bus.srcB = ids.src_b;
    assign bus.dstE = ids.dst_e;
    assign bus.dstM = ids.dst_m;

    // Read data is masked while reset is held; ids keep decoding.
    assign bus.valA    = rst ? '0 : ra_val;
    assign bus.valB    = rst ? '0 : rb_val;
    assign bus.dbg_val = rst ? '0 : dbg_val;

    y86_regfile #(
        .DATA_W    (DATA_W),
        .RSP_RESET (RSP_RESET)
    ) u_rf (
        .clk       (clk),
        .rst       (rst),
        .ra_sel_i  (ids.src_a),
        .rb_sel_i  (ids.src_b),
        .dbg_sel_i (bus.dbg_sel),
        .ra_val_o  (ra_val),
        .rb_val_o  (rb_val),
        .dbg_val_o (dbg_val),
        .we_i      (bus.wb_en),
        .e_dst_i   (ids.dst_e),
        .e_val_i   (bus.valE),
        .m_dst_i   (ids.dst_m),
        .m_val_i   (bus.valM)
    );
endmodule

// File: tb/tb_decode_writeback.sv
// Bench for decode_writeback: reference model of ids and register file,
// scoreboard of expected register contents read back via the debug port.
module tb_decode_writeback;
    localparam logic [63:0] RSPR = 64'h200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_writeback_if #(.DATA_W(64)) bus ();

    decode_writeback #(
        .DATA_W    (64),
        .RSP_RESET (RSPR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] mreg [15];

    typedef struct {
        logic [3:0]  idx;
        logic [63:0] exp;
    } sb_t;
    sb_t sbq [$];

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mrd(logic [3:0] id);
        return (id == 4'hF) ? 64'h0 : mreg[id];
    endfunction

    function automatic logic [3:0] x_srca(logic [3:0] ic, logic [3:0] ra);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
        if (ic inside {4'h9, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] x_srcb(logic [3:0] ic, logic [3:0] rb);
        if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] x_dste(logic [3:0] ic, logic [3:0] rb, logic c);
        if (ic == 4'h2) return c ? rb : 4'hF;
        if (ic inside {4'h3, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] x_dstm(logic [3:0] ic, logic [3:0] ra);
        return (ic inside {4'h5, 4'hB}) ? ra : 4'hF;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 15; i++) mreg[i] = 64'h0;
        mreg[4] = RSPR;
    endtask

    task automatic push_all();
        for (int i = 0; i < 15; i++) sbq.push_back('{idx: 4'(i), exp: mreg[i]});
    endtask

    task automatic drain(string nm);
        sb_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            bus.dbg_sel = e.idx;
            @(negedge clk);
            check($sformatf("%s.reg%0d", nm, e.idx), bus.dbg_val, e.exp);
        end
    endtask

    // Drive one instruction, check decode/read outputs before the edge,
    // commit on the edge, then read back the whole file.
    task automatic issue(string nm, logic [3:0] ic, logic [3:0] ra,
                         logic [3:0] rb, logic c, logic wb,
                         logic [63:0] ve, logic [63:0] vm, logic r);
        logic [3:0] sa, sb, de, dm;
        bus.icode = ic;
        bus.rA    = ra;
        bus.rB    = rb;
        bus.cnd   = c;
        bus.wb_en = wb;
        bus.valE  = ve;
        bus.valM  = vm;
        rst       = r;
        #1;
        sa = x_srca(ic, ra);
        sb = x_srcb(ic, rb);
        de = x_dste(ic, rb, c);
        dm = x_dstm(ic, ra);
        check({nm, ".srcA"}, 64'(bus.srcA), 64'(sa));
        check({nm, ".srcB"}, 64'(bus.srcB), 64'(sb));
        check({nm, ".dstE"}, 64'(bus.dstE), 64'(de));
        check({nm, ".dstM"}, 64'(bus.dstM), 64'(dm));
        check({nm, ".valA"}, bus.valA, r ? 64'h0 : mrd(sa));
        check({nm, ".valB"}, bus.valB, r ? 64'h0 : mrd(sb));
        @(posedge clk);
        if (r) model_reset();
        else if (wb) begin
            if (de != 4'hF) mreg[de] = ve;
            if (dm != 4'hF) mreg[dm] = vm;
        end
        #1;
        bus.wb_en = 1'b0;
        rst       = 1'b0;
        push_all();
        drain(nm);
    endtask

    initial begin
        rst         = 1'b1;
        bus.icode   = 4'h0;
        bus.rA      = 4'hF;
        bus.rB      = 4'hF;
        bus.cnd     = 1'b0;
        bus.wb_en   = 1'b0;
        bus.valE    = '0;
        bus.valM    = '0;
        bus.dbg_sel = 4'h4;
        for (int i = 0; i < 15; i++) mreg[i] = 64'h0;

        @(posedge clk);
        @(negedge clk);
        check("rst.dbg_forced0", bus.dbg_val, 64'h0);
        bus.icode = 4'h9;
        #1;
        check("rst.valA_forced0", bus.valA, 64'h0);
        check("rst.srcA_decoded", 64'(bus.srcA), 64'h4);
        bus.icode = 4'h0;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
        push_all();
        drain("reset");
        bus.dbg_sel = 4'hF;
        @(negedge clk);
        check("dbg_none", bus.dbg_val, 64'h0);

        issue("irmov2",  4'h3, 4'hF, 4'h2, 0, 1, 64'h1234, 64'h0, 0);
        issue("irmov1",  4'h3, 4'hF, 4'h1, 0, 1, 64'h77, 64'h0, 0);
        issue("irmovF",  4'h3, 4'hF, 4'hF, 0, 1, 64'hBAD, 64'h0, 0);
        issue("irmovW",  4'h3, 4'hF, 4'hE, 0, 1, 64'hFFFF_0000_DEAD_BEEF, 64'h0, 0);
        issue("rmmov",   4'h4, 4'h1, 4'h2, 0, 1, 64'h999, 64'h888, 0);
        issue("cmov_n",  4'h2, 4'h1, 4'h3, 0, 1, 64'h99, 64'h0, 0);
        issue("cmov_y",  4'h2, 4'h1, 4'h3, 1, 1, 64'h55, 64'h0, 0);
        issue("popq_sp", 4'hB, 4'h4, 4'hF, 0, 1, 64'h208, 64'hABC, 0);
        issue("popq_r0", 4'hB, 4'h0, 4'hF, 0, 1, 64'h208, 64'hABC, 0);
        issue("pushq_0", 4'hA, 4'h3, 4'hF, 0, 0, 64'h1F8, 64'h0, 0);
        issue("opq",     4'h6, 4'h1, 4'h2, 0, 1, 64'h12AB, 64'h0, 0);
        issue("mrmov",   4'h5, 4'h7, 4'h2, 0, 1, 64'h5555, 64'h7777, 0);
        issue("halt",    4'h0, 4'h1, 4'h2, 1, 1, 64'h11, 64'h22, 0);
        issue("inval",   4'hD, 4'h1, 4'h2, 1, 1, 64'h33, 64'h44, 0);
        issue("call",    4'h8, 4'hF, 4'hF, 0, 1, 64'h1F0, 64'h0, 0);
        issue("ret",     4'h9, 4'hF, 4'hF, 0, 1, 64'h1F8, 64'h66, 0);
        issue("rst_wr",  4'h3, 4'hF, 4'h2, 0, 1, 64'hDEAD, 64'h0, 1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
